// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator sequenced by a three-state FSM.
// Accepts one 8-bit operand and a shift count, then applies one 1-bit operation per cycle.
//
// Ports:
//   clk      system clock, rising-edge active
//   rst      asynchronous, active-high reset
//   start    request an operation; sampled only in IDLE
//   data_in  operand, latched on acceptance
//   amount   requested shift count 0..15, latched on acceptance
//   mode     00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right
//   busy     high while shifting (SHIFT state)
//   done     one-cycle pulse marking result valid (DONE state)
//   result   working register; holds the final value from DONE until the next accepted start
//   carry    last bit shifted or rotated out; 0 when the effective count is 0
module shift_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [3:0] amount,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_LSR = 2'b00;
    localparam logic [MODE_W-1:0] MODE_LSL = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ASR = 2'b10;
    localparam logic [MODE_W-1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              busy_d;
    logic              done_d;
    logic              accept;
    logic [CNT_W-1:0]  eff_n;
    logic [CNT_W-1:0]  cnt;
    logic [MODE_W-1:0] mode_q;

    assign accept = (state == ST_IDLE) && start;

    // Effective count: shifts saturate at the register width, rotates wrap modulo 8.
    always_comb begin
        eff_n = amount;
        if (mode == MODE_ROR) begin
            eff_n = {1'b0, amount[2:0]};
        end else if (amount > CNT_W'(DATA_W)) begin
            eff_n = CNT_W'(DATA_W);
        end
    end

    // State register; busy/done are registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (eff_n != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // The edge that performs the last shift also leaves SHIFT.
                if (cnt == CNT_W'(1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (next_state == ST_SHIFT) busy_d = 1'b1;
        if (next_state == ST_DONE)  done_d = 1'b1;
    end

    // Datapath: load on acceptance, one 1-bit operation per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            mode_q <= '0;
        end else if (accept) begin
            result <= data_in;
            carry  <= 1'b0;
            cnt    <= eff_n;
            mode_q <= mode;
        end else if (state == ST_SHIFT) begin
            cnt <= cnt - CNT_W'(1);
            unique case (mode_q)
                MODE_LSR: begin
                    result <= {1'b0, result[DATA_W-1:1]};
                    carry  <= result[0];
                end
                MODE_LSL: begin
                    result <= {result[DATA_W-2:0], 1'b0};
                    carry  <= result[DATA_W-1];
                end
                MODE_ASR: begin
                    result <= {result[DATA_W-1], result[DATA_W-1:1]};
                    carry  <= result[0];
                end
                MODE_ROR: begin
                    result <= {result[0], result[DATA_W-1:1]};
                    carry  <= result[0];
                end
                default: begin
                    result <= result;
                    carry  <= carry;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] amount;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;

    int tests = 0;
    int fails = 0;

    shift_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .amount  (amount),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: accept, count busy cycles, check the done cycle and the hold cycle.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [3:0] a,
                          input logic [1:0] m, input logic [7:0] er, input logic ec,
                          input int eb);
        int bc;
        int g;
        @(negedge clk);
        data_in = d; amount = a; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble operands after acceptance; they must not matter.
        data_in = ~d; amount = a + 4'd1; mode = m + 2'd1;
        bc = 0;
        g  = 0;
        while (busy === 1'b1 && g < 40) begin
            chk({tag, " done_while_busy"}, 32'(done), 32'd0);
            bc++;
            @(posedge clk); #1;
            g++;
        end
        chk({tag, " busy_cycles"}, 32'(bc), 32'(eb));
        chk({tag, " done"},        32'(done), 32'd1);
        chk({tag, " result"},      32'(result), 32'(er));
        chk({tag, " carry"},       32'(carry), 32'(ec));
        @(posedge clk); #1;
        chk({tag, " done_pulse"},  32'(done), 32'd0);
        chk({tag, " idle_busy"},   32'(busy), 32'd0);
        chk({tag, " result_hold"}, 32'(result), 32'(er));
        chk({tag, " carry_hold"},  32'(carry), 32'(ec));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0; amount = '0; mode = '0;
        #12;
        chk("reset busy",   32'(busy), 32'd0);
        chk("reset done",   32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset carry",  32'(carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("lsr3",      8'hB4, 4'd3,  2'b00, 8'h16, 1'b1, 3);
        run_op("asr2",      8'h80, 4'd2,  2'b10, 8'hE0, 1'b0, 2);
        run_op("lsl1",      8'h81, 4'd1,  2'b01, 8'h02, 1'b1, 1);
        run_op("ror3",      8'h81, 4'd3,  2'b11, 8'h30, 1'b0, 3);
        run_op("ror11",     8'h81, 4'd11, 2'b11, 8'h30, 1'b0, 3);
        run_op("lsr12",     8'hFF, 4'd12, 2'b00, 8'h00, 1'b1, 8);
        run_op("lsr0",      8'hA5, 4'd0,  2'b00, 8'hA5, 1'b0, 0);
        run_op("lsl8",      8'hFF, 4'd8,  2'b01, 8'h00, 1'b1, 8);
        run_op("ror8",      8'h3C, 4'd8,  2'b11, 8'h3C, 1'b0, 0);
        run_op("asr15",     8'h40, 4'd15, 2'b10, 8'h00, 1'b0, 8);

        // Reset during the second SHIFT cycle.
        @(negedge clk);
        data_in = 8'hB4; amount = 4'd3; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_pre busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("rst_pre result", 32'(result), 32'h5A);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid busy",   32'(busy), 32'd0);
        chk("rst_mid done",   32'(done), 32'd0);
        chk("rst_mid result", 32'(result), 32'd0);
        chk("rst_mid carry",  32'(carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_abandon done", 32'(done), 32'd0);
            chk("rst_abandon busy", 32'(busy), 32'd0);
        end
        run_op("post_rst", 8'h81, 4'd1, 2'b01, 8'h02, 1'b1, 1);

        // start held high: accepted only in IDLE.
        @(negedge clk);
        data_in = 8'h0F; amount = 4'd2; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hF0; amount = 4'd1; mode = 2'b01;
        chk("hold s1 busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("hold s2 busy", 32'(busy), 32'd1);
        chk("hold s2 done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("hold done",   32'(done), 32'd1);
        chk("hold busy_d", 32'(busy), 32'd0);
        chk("hold result", 32'(result), 32'h03);
        chk("hold carry",  32'(carry), 32'd1);
        @(posedge clk); #1;
        chk("hold idle busy", 32'(busy), 32'd0);
        chk("hold idle done", 32'(done), 32'd0);
        chk("hold idle result", 32'(result), 32'h03);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold2 busy",   32'(busy), 32'd1);
        chk("hold2 loaded", 32'(result), 32'hF0);
        @(posedge clk); #1;
        chk("hold2 done",   32'(done), 32'd1);
        chk("hold2 result", 32'(result), 32'hE0);
        chk("hold2 carry",  32'(carry), 32'd1);
        @(posedge clk); #1;
        chk("hold2 pulse",  32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
